// File: rtl/forward_hazard_unit.sv
// Pipeline operand-forwarding select and load-use / memory-wait hazard control.
// Forward selects are combinational except while frozen on a busy data memory.
module forward_hazard_unit #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*ADDR_W-1:0] id_ex_src,
  input  logic [NUM_SRC-1:0]        id_ex_src_vld,
  input  logic [NUM_SRC*ADDR_W-1:0] if_id_src,
  input  logic [NUM_SRC-1:0]        if_id_src_vld,
  input  logic [ADDR_W-1:0]         id_ex_rd,
  input  logic [ADDR_W-1:0]         ex_mem_rd,
  input  logic [ADDR_W-1:0]         mem_wb_rd,
  input  logic                      id_ex_reg_write,
  input  logic                      ex_mem_reg_write,
  input  logic                      mem_wb_reg_write,
  input  logic                      id_ex_mem_read,
  input  logic                      dmem_busy,
  output logic [NUM_SRC*2-1:0]      forward,
  output logic                      stall,
  output logic                      flush_ex,
  output logic                      freeze,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int unsigned FWD_W = NUM_SRC * 2;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [FWD_W-1:0] r_fwd_cap;

  logic [FWD_W-1:0] w_fwd_comb;
  logic             w_load_hazard;
  logic             w_stall;
  logic             w_freeze;

  // Address 0 can be hard-wired to zero, in which case it never aliases a producer.
  function automatic logic f_match(input logic [ADDR_W-1:0] a,
                                   input logic [ADDR_W-1:0] rd,
                                   input logic              we);
    return we && (a == rd) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    w_fwd_comb    = '0;
    w_load_hazard = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (id_ex_src_vld[i] &&
          f_match(id_ex_src[i*ADDR_W +: ADDR_W], ex_mem_rd, ex_mem_reg_write))
        w_fwd_comb[i*2 +: 2] = 2'd2;
      else if (id_ex_src_vld[i] &&
               f_match(id_ex_src[i*ADDR_W +: ADDR_W], mem_wb_rd, mem_wb_reg_write))
        w_fwd_comb[i*2 +: 2] = 2'd1;
      if (id_ex_mem_read && if_id_src_vld[i] &&
          f_match(if_id_src[i*ADDR_W +: ADDR_W], id_ex_rd, id_ex_reg_write))
        w_load_hazard = 1'b1;
    end
  end

  assign w_stall  = !reset && (r_state == ST_RUN) && w_load_hazard && !dmem_busy;
  assign w_freeze = !reset && dmem_busy;

  assign stall       = w_stall;
  assign flush_ex    = w_stall;
  assign freeze      = w_freeze;
  assign stall_count = r_count;

  // Captured selects hold only while memory is still busy; the exit cycle sees live values.
  always_comb begin
    forward = w_fwd_comb;
    if (reset)
      forward = '0;
    else if ((r_state == ST_MEM_WAIT) && dmem_busy)
      forward = r_fwd_cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_count   <= '0;
      r_fwd_cap <= '0;
    end else begin
      if ((w_stall || w_freeze) && (r_count != {CNT_W{1'b1}}))
        r_count <= r_count + CNT_W'(1);
      case (r_state)
        ST_RUN: begin
          if (dmem_busy) begin
            r_state   <= ST_MEM_WAIT;
            r_fwd_cap <= w_fwd_comb;
          end else if (w_load_hazard) begin
            r_state <= ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          if (dmem_busy) begin
            r_state   <= ST_MEM_WAIT;
            r_fwd_cap <= w_fwd_comb;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_busy)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: default instance plus a ZERO_REG=1, CNT_W=4 instance
// sharing stimulus, checked by directed scenarios and a randomized reference model.
module tb_forward_hazard_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  id_ex_src, if_id_src;
  logic [1:0]  id_ex_src_vld, if_id_src_vld;
  logic [2:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write;
  logic        id_ex_mem_read, dmem_busy;

  logic [3:0]  fwd_d, fwd_z;
  logic        stall_d, stall_z, flush_d, flush_z, freeze_d, freeze_z;
  logic [15:0] cnt_d;
  logic [3:0]  cnt_z;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = default instance, 1 = zero-reg instance.
  // Phase: 0 running, 1 one-cycle load stall, 2 waiting on memory.
  int         m_st  [2];
  int         m_cnt [2];
  logic [3:0] m_cap [2];

  forward_hazard_unit u_def (
    .clk(clk), .reset(reset),
    .id_ex_src(id_ex_src), .id_ex_src_vld(id_ex_src_vld),
    .if_id_src(if_id_src), .if_id_src_vld(if_id_src_vld),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .id_ex_reg_write(id_ex_reg_write), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_reg_write(mem_wb_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .dmem_busy(dmem_busy), .forward(fwd_d), .stall(stall_d),
    .flush_ex(flush_d), .freeze(freeze_d), .stall_count(cnt_d)
  );

  forward_hazard_unit #(.ZERO_REG(1), .CNT_W(4)) u_z (
    .clk(clk), .reset(reset),
    .id_ex_src(id_ex_src), .id_ex_src_vld(id_ex_src_vld),
    .if_id_src(if_id_src), .if_id_src_vld(if_id_src_vld),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .id_ex_reg_write(id_ex_reg_write), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_reg_write(mem_wb_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .dmem_busy(dmem_busy), .forward(fwd_z), .stall(stall_z),
    .flush_ex(flush_z), .freeze(freeze_z), .stall_count(cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit mt(int a, int rd, bit we, bit zr);
    return we && (a == rd) && !(zr && a == 0);
  endfunction

  function automatic logic [3:0] mfwd(bit zr);
    logic [3:0] v;
    v = '0;
    for (int ch = 0; ch < 2; ch++) begin
      int a;
      int sel;
      a = int'(id_ex_src[3*ch +: 3]);
      sel = 0;
      if (id_ex_src_vld[ch] && mt(a, int'(ex_mem_rd), ex_mem_reg_write, zr)) sel = 2;
      else if (id_ex_src_vld[ch] && mt(a, int'(mem_wb_rd), mem_wb_reg_write, zr)) sel = 1;
      v[2*ch +: 2] = 2'(sel);
    end
    return v;
  endfunction

  function automatic bit mhaz(bit zr);
    bit h;
    h = 0;
    for (int ch = 0; ch < 2; ch++)
      if (id_ex_mem_read && if_id_src_vld[ch] &&
          mt(int'(if_id_src[3*ch +: 3]), int'(id_ex_rd), id_ex_reg_write, zr))
        h = 1;
    return h;
  endfunction

  function automatic logic [3:0] exp_fwd(int k);
    if (reset) return 4'h0;
    if (m_st[k] == 2 && dmem_busy) return m_cap[k];
    return mfwd(k == 1);
  endfunction

  function automatic bit exp_stall(int k);
    return !reset && m_st[k] == 0 && mhaz(k == 1) && !dmem_busy;
  endfunction

  function automatic bit exp_freeze();
    return !reset && dmem_busy;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int cmax;
      cmax = (k == 0) ? 65535 : 15;
      if (reset) begin
        m_st[k] = 0; m_cnt[k] = 0; m_cap[k] = 4'h0;
      end else begin
        if ((exp_stall(k) || exp_freeze()) && m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
        if (m_st[k] == 2) begin
          if (!dmem_busy) m_st[k] = 0;
        end else if (dmem_busy) begin
          m_cap[k] = mfwd(k == 1);
          m_st[k] = 2;
        end else if (m_st[k] == 0 && mhaz(k == 1)) begin
          m_st[k] = 1;
        end else begin
          m_st[k] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_ex_src = '0; if_id_src = '0; id_ex_src_vld = '0; if_id_src_vld = '0;
    id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    id_ex_reg_write = 0; ex_mem_reg_write = 0; mem_wb_reg_write = 0;
    id_ex_mem_read = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic set_load_hazard();
    id_ex_mem_read = 1; id_ex_rd = 3'd5; id_ex_reg_write = 1;
    if_id_src = {3'd5, 3'd0}; if_id_src_vld = 2'b10;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    set_load_hazard();
    id_ex_src = {3'd1, 3'd3}; id_ex_src_vld = 2'b11;
    ex_mem_rd = 3'd3; ex_mem_reg_write = 1; dmem_busy = 1;
    #1;
    n_vec++; if (fwd_d !== 4'h0) begin n_err++; $display("FAIL reset_fwd got %h exp 0", fwd_d); end
    n_vec++; if (stall_d !== 1'b0 || flush_d !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b/%b exp 0/0", stall_d, flush_d); end
    n_vec++; if (freeze_d !== 1'b0 || freeze_z !== 1'b0) begin n_err++; $display("FAIL reset_freeze got %b/%b exp 0/0", freeze_d, freeze_z); end
    tick();
    tick();
    reset = 0;
    idle_inputs();
    #1;
    n_vec++; if (cnt_d !== 16'd0 || cnt_z !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d/%0d exp 0/0", cnt_d, cnt_z); end
  endtask

  task automatic test_forward_priority();
    do_reset();
    id_ex_src = {3'd6, 3'd3}; id_ex_src_vld = 2'b01;
    ex_mem_rd = 3'd3; ex_mem_reg_write = 1; mem_wb_rd = 3'd3; mem_wb_reg_write = 1;
    #1;
    n_vec++; if (fwd_d !== 4'h2) begin n_err++; $display("FAIL fwd_exmem_wins got %h exp 2", fwd_d); end
    ex_mem_reg_write = 0;
    #1;
    n_vec++; if (fwd_d !== 4'h1) begin n_err++; $display("FAIL fwd_memwb got %h exp 1", fwd_d); end
    id_ex_src = {3'd3, 3'd3}; id_ex_src_vld = 2'b10; ex_mem_rd = 3'd6; ex_mem_reg_write = 1;
    #1;
    n_vec++; if (fwd_d !== 4'h4) begin n_err++; $display("FAIL fwd_ch1_only got %h exp 4", fwd_d); end
    id_ex_src_vld = 2'b00;
    #1;
    n_vec++; if (fwd_d !== 4'h0) begin n_err++; $display("FAIL fwd_invalid got %h exp 0", fwd_d); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    id_ex_src = 6'd0; id_ex_src_vld = 2'b01; ex_mem_rd = 3'd0; ex_mem_reg_write = 1;
    #1;
    n_vec++; if (fwd_z !== 4'h0) begin n_err++; $display("FAIL zero_reg_fwd got %h exp 0", fwd_z); end
    n_vec++; if (fwd_d !== 4'h2) begin n_err++; $display("FAIL zero_reg_default got %h exp 2", fwd_d); end
  endtask

  task automatic test_load_stall();
    do_reset();
    set_load_hazard();
    #1;
    n_vec++; if (stall_d !== 1'b1 || flush_d !== 1'b1) begin n_err++; $display("FAIL ld_cycle1 got %b/%b exp 1/1", stall_d, flush_d); end
    tick();
    n_vec++; if (stall_d !== 1'b0 || flush_d !== 1'b0) begin n_err++; $display("FAIL ld_cycle2 got %b/%b exp 0/0", stall_d, flush_d); end
    n_vec++; if (cnt_d !== 16'd1) begin n_err++; $display("FAIL ld_count got %0d exp 1", cnt_d); end
    tick();
    n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL ld_back_in_run got %b exp 1", stall_d); end
    id_ex_mem_read = 0;
    #1;
    n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL ld_cleared got %b exp 0", stall_d); end
    tick();
    n_vec++; if (cnt_d !== 16'd1) begin n_err++; $display("FAIL ld_count_final got %0d exp 1", cnt_d); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    id_ex_src = {3'd7, 3'd2}; id_ex_src_vld = 2'b01; ex_mem_rd = 3'd2; ex_mem_reg_write = 1;
    dmem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (freeze_d !== 1'b1) begin n_err++; $display("FAIL mw_freeze c%0d got %b exp 1", c, freeze_d); end
      n_vec++; if (fwd_d !== 4'h2) begin n_err++; $display("FAIL mw_fwd_hold c%0d got %h exp 2", c, fwd_d); end
      tick();
      ex_mem_rd = 3'(4 + c);
    end
    dmem_busy = 0;
    #1;
    n_vec++; if (freeze_d !== 1'b0) begin n_err++; $display("FAIL mw_release got %b exp 0", freeze_d); end
    n_vec++; if (cnt_d !== 16'd3) begin n_err++; $display("FAIL mw_count got %0d exp 3", cnt_d); end
    tick();
    n_vec++; if (fwd_d !== 4'h0) begin n_err++; $display("FAIL mw_fwd_live got %h exp 0", fwd_d); end
    set_load_hazard();
    #1;
    n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL mw_back_run got %b exp 1", stall_d); end
  endtask

  task automatic test_hazard_and_busy();
    do_reset();
    set_load_hazard();
    dmem_busy = 1;
    #1;
    n_vec++; if (flush_d !== 1'b0 || stall_d !== 1'b0) begin n_err++; $display("FAIL hb_flush got %b/%b exp 0/0", flush_d, stall_d); end
    n_vec++; if (freeze_d !== 1'b1) begin n_err++; $display("FAIL hb_freeze got %b exp 1", freeze_d); end
    tick();
    dmem_busy = 0;
    #1;
    n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL hb_wait_exit got %b exp 0", stall_d); end
    tick();
    n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL hb_run got %b exp 1", stall_d); end
  endtask

  task automatic test_saturate();
    do_reset();
    dmem_busy = 1;
    for (int c = 0; c < 20; c++) tick();
    n_vec++; if (cnt_z !== 4'd15) begin n_err++; $display("FAIL sat_cnt4 got %0d exp 15", cnt_z); end
    n_vec++; if (cnt_d !== 16'd20) begin n_err++; $display("FAIL sat_cnt16 got %0d exp 20", cnt_d); end
    reset = 1;
    #1;
    n_vec++; if (freeze_z !== 1'b0 || fwd_z !== 4'h0) begin n_err++; $display("FAIL sat_reset_out got %b/%h exp 0/0", freeze_z, fwd_z); end
    tick();
    reset = 0;
    dmem_busy = 0;
    set_load_hazard();
    #1;
    n_vec++; if (cnt_z !== 4'd0 || cnt_d !== 16'd0) begin n_err++; $display("FAIL sat_reset_cnt got %0d/%0d exp 0/0", cnt_z, cnt_d); end
    n_vec++; if (stall_z !== 1'b1) begin n_err++; $display("FAIL sat_reset_run got %b exp 1", stall_z); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset            = ($urandom_range(0, 31) == 0);
      id_ex_src        = 6'($urandom);
      if_id_src        = 6'($urandom);
      id_ex_src_vld    = 2'($urandom);
      if_id_src_vld    = 2'($urandom);
      id_ex_rd         = $urandom_range(0, 1) ? id_ex_src[2:0] : 3'($urandom);
      ex_mem_rd        = $urandom_range(0, 1) ? id_ex_src[5:3] : 3'($urandom);
      mem_wb_rd        = $urandom_range(0, 1) ? id_ex_src[2:0] : 3'($urandom);
      if ($urandom_range(0, 1) == 1) if_id_src[5:3] = id_ex_rd;
      id_ex_reg_write  = 1'($urandom);
      ex_mem_reg_write = 1'($urandom);
      mem_wb_reg_write = 1'($urandom);
      id_ex_mem_read   = 1'($urandom);
      dmem_busy        = ($urandom_range(0, 3) == 0);
      #1;
      n_vec++; if (fwd_d !== exp_fwd(0)) begin n_err++; $display("FAIL rnd_fwd_d cyc %0d got %h exp %h", cyc, fwd_d, exp_fwd(0)); end
      n_vec++; if (fwd_z !== exp_fwd(1)) begin n_err++; $display("FAIL rnd_fwd_z cyc %0d got %h exp %h", cyc, fwd_z, exp_fwd(1)); end
      n_vec++; if (stall_d !== exp_stall(0) || flush_d !== exp_stall(0)) begin n_err++; $display("FAIL rnd_stall_d cyc %0d got %b/%b exp %b", cyc, stall_d, flush_d, exp_stall(0)); end
      n_vec++; if (stall_z !== exp_stall(1) || flush_z !== exp_stall(1)) begin n_err++; $display("FAIL rnd_stall_z cyc %0d got %b/%b exp %b", cyc, stall_z, flush_z, exp_stall(1)); end
      n_vec++; if (freeze_d !== exp_freeze() || freeze_z !== exp_freeze()) begin n_err++; $display("FAIL rnd_freeze cyc %0d got %b/%b exp %b", cyc, freeze_d, freeze_z, exp_freeze()); end
      n_vec++; if (int'(cnt_d) != m_cnt[0] || int'(cnt_z) != m_cnt[1] || $isunknown({cnt_d, cnt_z})) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d/%0d exp %0d/%0d", cyc, cnt_d, cnt_z, m_cnt[0], m_cnt[1]); end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_cnt[k] = 0; m_cap[k] = 4'h0; end
    idle_inputs();
    reset = 1;
    test_reset();
    test_forward_priority();
    test_zero_reg();
    test_load_stall();
    test_mem_wait();
    test_hazard_and_busy();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 3: register-address width, legal range 2..6.
REQ-002 Parameter NUM_SRC, default 2: source-operand channels, legal range 1..4.
REQ-003 Parameter ZERO_REG, default 0: if 1, address 0 never matches for forwarding or hazard detection.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 id_ex_src  input  NUM_SRC*ADDR_W  EX-stage source addresses; channel i is bits [i*ADDR_W +: ADDR_W].
REQ-008 id_ex_src_vld  input  NUM_SRC  per-channel EX source in use.
REQ-009 if_id_src  input  NUM_SRC*ADDR_W  ID-stage source addresses, same packing.
REQ-010 if_id_src_vld  input  NUM_SRC  per-channel ID source in use.
REQ-011 id_ex_rd, ex_mem_rd, mem_wb_rd  input  ADDR_W each  stage destination addresses.
REQ-012 id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write  input  1 each  stage writes a register.
REQ-013 id_ex_mem_read  input  1  EX-stage instruction is a load.
REQ-014 dmem_busy  input  1  data memory has not completed the current access.
REQ-015 forward  output  NUM_SRC*2  per-channel select: 0 register file, 1 MEM/WB, 2 EX/MEM; 3 never driven.
REQ-016 stall  output  1  hold PC and IF/ID.
REQ-017 flush_ex  output  1  insert bubble into ID/EX.
REQ-018 freeze  output  1  hold all pipeline registers.
REQ-019 stall_count  output  CNT_W  total stall-or-freeze cycles since reset, saturating.

Function
REQ-020 Match(a,rd,we) SHALL be we and a==rd and not (ZERO_REG and a==0).
REQ-021 In RUN, forward[i] SHALL be 2 if Match(id_ex_src[i],ex_mem_rd,ex_mem_reg_write) and id_ex_src_vld[i], else 1 if the MEM/WB match holds, else 0; combinational, zero latency.
REQ-022 When both EX/MEM and MEM/WB match, EX/MEM SHALL win.
REQ-023 load_hazard SHALL be id_ex_mem_read and, for any channel i, if_id_src_vld[i] and Match(if_id_src[i],id_ex_rd,id_ex_reg_write).
REQ-024 FSM states SHALL be RUN, LOAD_STALL, MEM_WAIT.
REQ-025 RUN->MEM_WAIT when dmem_busy; else RUN->LOAD_STALL when load_hazard; else stay in RUN.
REQ-026 LOAD_STALL->MEM_WAIT when dmem_busy; else always ->RUN after exactly one cycle, even if load_hazard is still asserted.
REQ-027 MEM_WAIT->RUN on the first cycle dmem_busy is sampled low.
REQ-028 dmem_busy SHALL take priority over load_hazard in the same cycle.
REQ-029 stall and flush_ex SHALL be 1 combinationally in the RUN cycle where load_hazard is 1 and dmem_busy is 0; they SHALL be 0 in all other cycles, including LOAD_STALL.
REQ-030 freeze SHALL be 1 combinationally whenever dmem_busy is 1, in any state; it SHALL be 0 otherwise.
REQ-031 On the RUN or LOAD_STALL cycle that enters MEM_WAIT, the unit SHALL register the current forward vector.
REQ-032 While in MEM_WAIT, forward SHALL output the registered vector, unaffected by input changes.
REQ-033 On the cycle MEM_WAIT exits to RUN, forward SHALL return to the combinational value.
REQ-034 stall_count SHALL increment by 1 on every edge where stall or freeze was 1.
REQ-035 stall_count SHALL hold at 2^CNT_W-1 without wrapping.

Reset
REQ-036 While reset is 1 at a rising edge: state <- RUN, stall_count <- 0, captured forward vector <- 0.
REQ-037 Reset SHALL override every other input, including mid-MEM_WAIT and mid-LOAD_STALL.
REQ-038 While reset is asserted, stall, flush_ex and freeze SHALL be 0 and forward SHALL be all 0.

Verification
REQ-039 Defaults; EX src0=3, ex_mem_rd=3, ex_mem_reg_write=1, mem_wb_rd=3, mem_wb_reg_write=1 -> forward[1:0]=2; clear ex_mem_reg_write -> forward[1:0]=1.
REQ-040 ZERO_REG=1; src0=0, ex_mem_rd=0, ex_mem_reg_write=1 -> forward[1:0]=0.
REQ-041 id_ex_mem_read=1, id_ex_rd=5, id_ex_reg_write=1, if_id src1=5 valid, inputs held 2 cycles -> stall=flush_ex=1 in cycle 1 only; state LOAD_STALL then RUN; stall_count=1.
REQ-042 Enter MEM_WAIT with forward=0x2 (src0=2), hold dmem_busy 3 cycles while changing ex_mem_rd -> freeze=1 for 3 cycles; forward stays 0x2; stall_count=3; RUN after dmem_busy drops.
REQ-043 load_hazard and dmem_busy asserted together -> MEM_WAIT, flush_ex=0, freeze=1.
REQ-044 CNT_W=4; hold dmem_busy 20 cycles -> stall_count saturates at 15; assert reset in MEM_WAIT -> next cycle state RUN, stall_count=0.
